// File: rtl/chan_scatter.sv
// chan_scatter: one-to-many distributor. Accepts WIDTH-bit words on a single
// valid/ready input and deals them strictly round-robin into Port_Num
// registered output channels (a..h). Each channel holds its word with a valid
// flag until the consumer acknowledges it. Channels at index >= Port_Num are
// tied off: data 0, vld 0.
module chan_scatter #(
    parameter int Port_Num = 2,
    parameter int WIDTH    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] e,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] h,
    output logic [7:0]       vld,
    input  logic [7:0]       ack,
    output logic [2:0]       ptr,
    output logic             full,
    output logic [3:0]       count
);
    localparam logic [2:0] LAST_PTR = 3'(Port_Num - 1);
    localparam logic [3:0] FULL_CNT = 4'(Port_Num);

    logic [7:0]       r_vld;
    logic [2:0]       r_ptr;
    logic [3:0]       r_count;
    logic             r_full;

    logic             w_accept;
    logic [7:0]       w_lane_en;
    logic [7:0]       w_ptr_oh;
    logic [7:0]       w_ack_hon;
    logic [7:0]       w_vld_nxt;
    logic [3:0]       w_ack_cnt;
    logic [3:0]       w_cnt_nxt;
    logic [2:0]       w_ptr_nxt;
    logic [WIDTH-1:0] w_chan [8];

    // Ready looks only at the pointer channel's registered valid flag, so an
    // ack in the same cycle never opens the slot (no same-cycle replace).
    assign din_ready = ~r_vld[r_ptr];
    assign w_accept  = din_valid & din_ready;
    assign w_ptr_oh  = 8'h01 << r_ptr;

    // Per-lane holding registers; lanes beyond Port_Num are constant zero.
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
        if (gi < Port_Num) begin : g_act
            logic [WIDTH-1:0] r_q;
            // Capture din into this lane when it is the accepting target.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)                             r_q <= '0;
                else if (w_accept && r_ptr == 3'(gi))   r_q <= din;
            end
            assign w_chan[gi]    = r_q;
            assign w_lane_en[gi] = 1'b1;
        end else begin : g_off
            assign w_chan[gi]    = '0;
            assign w_lane_en[gi] = 1'b0;
        end
    end

    // Next-state: honoured acks, new valid vector, running count and pointer.
    always_comb begin
        w_ack_hon = ack & r_vld & w_lane_en;
        w_vld_nxt = (r_vld & ~w_ack_hon) | (w_accept ? w_ptr_oh : 8'h00);
        w_ack_cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            w_ack_cnt = w_ack_cnt + 4'(w_ack_hon[i]);
        end
        w_cnt_nxt = r_count + {3'b000, w_accept} - w_ack_cnt;
        w_ptr_nxt = r_ptr;
        if (w_accept) begin
            w_ptr_nxt = (r_ptr == LAST_PTR) ? 3'd0 : r_ptr + 3'd1;
        end
    end

    // Control state: valid flags, dealing pointer, occupancy and full flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld   <= 8'h00;
            r_ptr   <= 3'd0;
            r_count <= 4'd0;
            r_full  <= 1'b0;
        end else begin
            r_vld   <= w_vld_nxt & w_lane_en;
            r_ptr   <= w_ptr_nxt;
            r_count <= w_cnt_nxt;
            r_full  <= (w_cnt_nxt == FULL_CNT);
        end
    end

    assign a     = w_chan[0];
    assign b     = w_chan[1];
    assign c     = w_chan[2];
    assign d     = w_chan[3];
    assign e     = w_chan[4];
    assign f     = w_chan[5];
    assign g     = w_chan[6];
    assign h     = w_chan[7];
    assign vld   = r_vld;
    assign ptr   = r_ptr;
    assign count = r_count;
    assign full  = r_full;
endmodule

// File: doc/chan_scatter.md
Name: chan_scatter

Overview:
- One-to-many distributor: the inverse of the library's many-input reduction gates.
- Accepts a stream of WIDTH-bit words on a single valid/ready input.
- Deals each word round-robin into one of Port_Num registered output channels a..h.
- Each channel holds its word, with a valid flag, until its consumer acknowledges it.

Parameters:
- Port_Num, 2, number of active output channels (2..8); channels at index Port_Num and above are unused.
- WIDTH, 1, data width of the input word and of each output channel (1..32).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  WIDTH  input word.
- din_valid  input  1  din holds a word to transfer.
- din_ready  output  1  block can accept din this cycle.
- a, b, c, d, e, f, g, h  output  WIDTH each  channel 0..7 holding registers.
- vld  output  8  vld[i]=1 means channel i holds an unacknowledged word.
- ack  input  8  ack[i] consumes channel i's word.
- ptr  output  3  index of the channel that receives the next accepted word.
- full  output  1  all Port_Num channels valid.
- count  output  4  number of channels with vld=1 (0..Port_Num).

Behaviour:
- Reset (rst_n=0, asynchronous) forces:
  - a..h = 0, vld = 0, ptr = 0, count = 0, full = 0.
  - Consequently din_ready = 1 once reset is released.
  - Reset mid-transfer discards all held words; no partial state survives.
- din_ready:
  - Combinational: din_ready = ~vld[ptr].
  - Does not depend on din_valid or ack in the same cycle, so there is no same-cycle replace.
- Accept:
  - Occurs when din_valid & din_ready at a rising edge.
  - Channel[ptr] <= din and vld[ptr] <= 1.
  - ptr <= (ptr == Port_Num-1) ? 0 : ptr+1.
  - The word is visible on the channel output one cycle after the accepting edge.
- Stall: if din_valid=1 and vld[ptr]=1, nothing changes; ptr does not skip ahead to a free channel. Strict in-order dealing.
- Release:
  - ack[i]=1 with vld[i]=1 clears vld[i] at the edge.
  - The data register keeps its last value; only vld is meaningful.
  - ack[i] with vld[i]=0 is ignored.
  - ack bits at index Port_Num and above are always ignored.
- Simultaneous events:
  - Accept into channel p and ack of a different channel q in the same cycle: both take effect.
  - count changes by +1-1 = 0.
  - Accept and ack cannot target the same channel in one cycle, because accept requires vld[ptr]=0.
  - Multiple ack bits in one cycle are all honoured.
- count:
  - Registered.
  - next = count + accept - (number of honoured acks).
  - Must always equal popcount(vld).
- full:
  - Registered, equal to (next count == Port_Num).
  - When full=1, din_ready is necessarily 0.
- Unused channels (index at least Port_Num): output 0 and vld bit 0 permanently.
- No combinational path from din to any channel output.
- din_ready depends only on registered state.

Test Plan:
- Reset then fill:
  - Stimulus: Port_Num=4, WIDTH=8, rst_n low then high; din_valid held 1 with din=0x11, 0x22, 0x33, 0x44 on successive accepts, ack=0.
  - Response: a=0x11, b=0x22, c=0x33, d=0x44, vld=0x0F, count=4, full=1, din_ready=0, ptr=0, e..h=0.
- Stall on the pointer channel:
  - Stimulus: from the full state, ack[2]=1 for one cycle, then din=0x55 valid.
  - Response: vld=0x0B and count=3, but din_ready stays 0 (ptr=0 and vld[0]=1).
  - Then ack[0]=1: din_ready=1, 0x55 lands in a, ptr=1.
- Wrap-around:
  - Stimulus: Port_Num=3; present 7 words, each channel acked one cycle after it fills.
  - Response: word order across channels is a, b, c, a, b, c, a; ptr sequence 0, 1, 2, 0, 1, 2, 0, 1.
- Simultaneous accept and ack:
  - Stimulus: vld=0x02, ptr=0; in one cycle din_valid=1 with din=0x9A and ack=0x02.
  - Response: vld=0x01, a=0x9A, count stays 1.
- Spurious and out-of-range acks:
  - Stimulus: Port_Num=2, ack=0xFC pulsed with vld=0x01.
  - Response: vld, count and ptr unchanged.
- Async reset mid-operation:
  - Stimulus: assert rst_n=0 between clock edges with vld=0x05.
  - Response: outputs go to zero immediately without a clock edge; after release, the first accepted word lands in channel a.
